perceptron_predictor: RTL and testbench
=======================================

PERCEPTRON_PREDICTOR -- requirements
Module: perceptron_predictor

Interface
REQ-001 SHALL have parameters: HIST_LEN, 12, global history bits; ENTRIES, 64, perceptron rows (power of 2); WEIGHT_W, 8, signed weight width; THETA, 37, training threshold.
REQ-002 SHALL use clock clk and reset reset (synchronous, active-high); ports follow as name direction width meaning.
REQ-003 clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-004 lookup_valid  in  1  lookup request; lookup_pc  in  32  fetch PC; lookup_ready  out  1  low during INIT.
REQ-005 pred_valid  out  1  prediction valid; pred_taken  out  1  direction; pred_sum  out  SW  signed dot product, SW = WEIGHT_W+clog2(HIST_LEN+2); pred_ghr  out  HIST_LEN  history used.
REQ-006 update_valid  in  1  resolved branch; update_pc  in  32; update_taken  in  1; update_sum  in  SW; update_ghr  in  HIST_LEN; update_mispred  in  1.
REQ-007 dbg_sel  in  2  counter select; dbg_data  out  32  selected counter.

Function
REQ-008 Row index SHALL be pc[clog2(ENTRIES)+1:2]; row = HIST_LEN weights plus one bias weight.
REQ-009 Lookup accepted when lookup_valid & lookup_ready; pred_valid SHALL assert exactly 1 cycle later for 1 cycle; back-to-back lookups give one prediction per cycle.
REQ-010 pred_sum = bias + sum over i of (ghr[i] ? +w[i] : -w[i]), sign-extended to SW, no overflow; pred_taken = (pred_sum >= 0).
REQ-011 History snapshot SHALL be captured at acceptance from GHR next-state (includes any shift committing that same cycle); pred_ghr = snapshot.
REQ-012 Speculative GHR: in pred_valid cycle GHR <= {GHR[HIST_LEN-2:0], pred_taken}.
REQ-013 Recovery: update_valid & update_mispred SHALL set GHR <= {update_ghr[HIST_LEN-2:0], update_taken}, overriding any same-cycle speculative shift.
REQ-014 Training on update_valid when update_mispred or |update_sum| <= THETA: each w[i] += (update_taken == update_ghr[i]) ? +1 : -1; bias += update_taken ? +1 : -1.
REQ-015 Weights SHALL saturate at -(2^(WEIGHT_W-1)) and 2^(WEIGHT_W-1)-1; no wrap.
REQ-016 Training write SHALL commit at the end of the update cycle; a lookup accepted in that cycle to the same row reads pre-update weights.
REQ-017 Counters (32-bit, wrap): lookup_count (accepted lookups), update_count (update_valid), mispred_count (update_valid & update_mispred), train_count (trainings); dbg_sel 0..3 selects them in that order, combinationally.
REQ-018 update_valid during INIT SHALL be ignored (no training, no GHR change, no count).

Reset
REQ-019 reset SHALL enter INIT: GHR, snapshot, all counters, pred_valid, pred_taken, pred_sum, pred_ghr = 0; lookup_ready = 0.
REQ-020 INIT SHALL clear one row per cycle, rows 0..ENTRIES-1, then go RUN; lookup_ready = 1 from first RUN cycle (ENTRIES cycles after reset deasserts).
REQ-021 reset asserted in INIT or RUN SHALL restart INIT from row 0 and drop any in-flight prediction.

Configuration
REQ-022 Macro PERCEPTRON_BIAS_EN: defined -> bias weight stored, summed, trained per REQ-010/014; undefined -> no bias storage, bias term is 0 in sum and training.

Verification
REQ-023 Reset then 64 idle cycles -> lookup_ready rises on cycle 64; first lookup pc=0x40 -> pred_sum=0, pred_taken=1, pred_ghr=0.
REQ-024 Train pc=0x100, update_ghr=all-ones, taken=1, sum=0, 140 times -> all weights saturate at 127; lookup, GHR all-ones -> pred_sum = 127*13 (bias on) or 127*12 (bias off).
REQ-025 Update with |update_sum|=38, mispred=0 -> no weight change, train_count unchanged; |update_sum|=37 -> trained.
REQ-026 Three back-to-back lookups, predictions T,N,T -> GHR low bits 101; mispredict same cycle as third pred, update_ghr=0x0AA, taken=0 -> GHR=0x154.
REQ-027 Same-row lookup and training in same cycle -> prediction uses old weights; next lookup shows updated weights.
REQ-028 reset pulsed at INIT row 30 -> lookup_ready low for 64 further cycles; all counters read 0 via dbg_sel 0..3.

Source files
------------

// File: rtl/perceptron_predictor.sv
// Perceptron branch direction predictor with a global history register.
//
// Optional feature macro: PERCEPTRON_BIAS_EN. When defined, each row also holds a
// bias weight that is summed and trained. When undefined, there is no bias
// storage and the bias term is zero.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset (starts row clearing)
//   lookup_valid/pc   lookup request; accepted when lookup_ready is high
//   lookup_ready      low while the weight table is being cleared
//   pred_valid        one-cycle pulse, one cycle after an accepted lookup
//   pred_taken        predicted direction (pred_sum >= 0)
//   pred_sum          signed dot product of weights and history
//   pred_ghr          history snapshot used for the prediction
//   update_*          resolved branch: pc, outcome, sum and history at prediction,
//                     mispredict flag (mispredict also repairs the history)
//   dbg_sel/dbg_data  counter readout: 0 lookups, 1 updates, 2 mispredicts, 3 trainings
module perceptron_predictor #(
  parameter int unsigned HIST_LEN = 12,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned THETA    = 37,
  localparam int unsigned SW      = WEIGHT_W + $clog2(HIST_LEN + 2),
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  output logic                lookup_ready,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [SW-1:0]       pred_sum,
  output logic [HIST_LEN-1:0] pred_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_taken,
  input  logic [SW-1:0]       update_sum,
  input  logic [HIST_LEN-1:0] update_ghr,
  input  logic                update_mispred,
  input  logic [1:0]          dbg_sel,
  output logic [31:0]         dbg_data
);

  localparam logic [WEIGHT_W-1:0] WMax = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] WMin = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic [WEIGHT_W-1:0] WOne = WEIGHT_W'(1);
  localparam int                  ThetaInt = int'(THETA);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_row_q, init_row_d;

  logic [WEIGHT_W-1:0] weights_q [ENTRIES][HIST_LEN];
  logic [WEIGHT_W-1:0] w_new [HIST_LEN];
`ifdef PERCEPTRON_BIAS_EN
  logic [WEIGHT_W-1:0] bias_q [ENTRIES];
  logic [WEIGHT_W-1:0] bias_new;
`endif

  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic                pred_valid_q, pred_taken_q;
  logic [SW-1:0]       pred_sum_q;
  logic [HIST_LEN-1:0] pred_ghr_q;
  logic [31:0]         lookup_count_q, update_count_q, mispred_count_q, train_count_q;

  logic [IDX_W-1:0]    lookup_row, update_row;
  logic [SW-1:0]       lookup_sum;
  logic                lookup_fire, update_fire, train_en, in_band;
  int                  update_sum_int;
  logic                unused_pc_bits;

  assign lookup_row  = lookup_pc[IDX_W+1:2];
  assign update_row  = update_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            update_pc[31:IDX_W+2], update_pc[1:0]};

  assign lookup_ready = (state_q == StRun);
  assign lookup_fire  = lookup_valid & lookup_ready;
  // Updates arriving while the table is being cleared are dropped entirely.
  assign update_fire  = update_valid & (state_q == StRun) & ~reset;

  assign update_sum_int = int'($signed(update_sum));
  assign in_band  = (update_sum_int <= ThetaInt) && (update_sum_int >= -ThetaInt);
  assign train_en = update_fire & (update_mispred | in_band);

  function automatic logic [SW-1:0] sext(input logic [WEIGHT_W-1:0] w);
    return {{(SW-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w,
                                                   input logic up);
    if (up) return (w == WMax) ? w : w + WOne;
    return (w == WMin) ? w : w - WOne;
  endfunction

  // ---------------------------------------------------------------------------
  // Init / run FSM: clears one row per cycle after reset
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    init_row_d = init_row_q;
    case (state_q)
      StInit: begin
        init_row_d = init_row_q + IDX_W'(1);
        if (init_row_q == IDX_W'(ENTRIES - 1)) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      init_row_q <= '0;
    end else begin
      state_q    <= state_d;
      init_row_q <= init_row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dot product against the history the lookup will snapshot (ghr_d), using the
  // weights as they stand this cycle, so a same-cycle training write is not seen.
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef PERCEPTRON_BIAS_EN
    lookup_sum = sext(bias_q[lookup_row]);
`else
    lookup_sum = '0;
`endif
    for (int i = 0; i < HIST_LEN; i++) begin
      if (ghr_d[i]) lookup_sum = lookup_sum + sext(weights_q[lookup_row][i]);
      else          lookup_sum = lookup_sum - sext(weights_q[lookup_row][i]);
    end
  end

  // Trained row: agree with the outcome -> strengthen, disagree -> weaken.
  always_comb begin
    for (int i = 0; i < HIST_LEN; i++) begin
      w_new[i] = sat_step(weights_q[update_row][i], update_taken == update_ghr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      for (int i = 0; i < HIST_LEN; i++) weights_q[init_row_q][i] <= '0;
    end else if (train_en) begin
      for (int i = 0; i < HIST_LEN; i++) weights_q[update_row][i] <= w_new[i];
    end
  end

`ifdef PERCEPTRON_BIAS_EN
  assign bias_new = sat_step(bias_q[update_row], update_taken);

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      bias_q[init_row_q] <= '0;
    end else if (train_en) begin
      bias_q[update_row] <= bias_new;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Global history: speculative shift on each prediction; a mispredict repair
  // takes priority over a shift in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ghr_d = ghr_q;
    if (pred_valid_q) ghr_d = {ghr_q[HIST_LEN-2:0], pred_taken_q};
    if (update_fire && update_mispred) ghr_d = {update_ghr[HIST_LEN-2:0], update_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q           <= '0;
      pred_valid_q    <= 1'b0;
      pred_taken_q    <= 1'b0;
      pred_sum_q      <= '0;
      pred_ghr_q      <= '0;
      lookup_count_q  <= '0;
      update_count_q  <= '0;
      mispred_count_q <= '0;
      train_count_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= lookup_fire;
      if (lookup_fire) begin
        pred_sum_q   <= lookup_sum;
        pred_taken_q <= ~lookup_sum[SW-1];
        pred_ghr_q   <= ghr_d;
      end
      if (lookup_fire)                    lookup_count_q  <= lookup_count_q + 32'd1;
      if (update_fire)                    update_count_q  <= update_count_q + 32'd1;
      if (update_fire && update_mispred)  mispred_count_q <= mispred_count_q + 32'd1;
      if (train_en)                       train_count_q   <= train_count_q + 32'd1;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_sum   = pred_sum_q;
  assign pred_ghr   = pred_ghr_q;

  always_comb begin
    dbg_data = lookup_count_q;
    case (dbg_sel)
      2'd0:    dbg_data = lookup_count_q;
      2'd1:    dbg_data = update_count_q;
      2'd2:    dbg_data = mispred_count_q;
      2'd3:    dbg_data = train_count_q;
      default: dbg_data = lookup_count_q;
    endcase
  end

endmodule

// File: tb/tb_perceptron_predictor.sv
// Directed bench for perceptron_predictor (default parameters). Expected sums are
// hand-computed; the bias contribution is added only when PERCEPTRON_BIAS_EN is set.
module tb_perceptron_predictor;

  localparam int SW = 12;
`ifdef PERCEPTRON_BIAS_EN
  localparam bit BiasOn = 1'b1;
`else
  localparam bit BiasOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_valid;
  logic [31:0]   lookup_pc;
  logic          lookup_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic [SW-1:0] pred_sum;
  logic [11:0]   pred_ghr;
  logic          update_valid;
  logic [31:0]   update_pc;
  logic          update_taken;
  logic [SW-1:0] update_sum;
  logic [11:0]   update_ghr;
  logic          update_mispred;
  logic [1:0]    dbg_sel;
  logic [31:0]   dbg_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  perceptron_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .lookup_ready   (lookup_ready),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_sum       (pred_sum),
    .pred_ghr       (pred_ghr),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_sum     (update_sum),
    .update_ghr     (update_ghr),
    .update_mispred (update_mispred),
    .dbg_sel        (dbg_sel),
    .dbg_data       (dbg_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mispred;
    int          sum;
    logic [11:0] ghr;
    int          exp_upd;
    int          exp_mp;
    int          exp_tr;
  } upd_vec_t;

  typedef struct {
    logic [31:0] pc;
    int          sum_nb;   // sum without bias
    int          bias;
    logic        taken;
    logic [11:0] ghr;
  } lk_vec_t;

  upd_vec_t uv[7];
  lk_vec_t  lv[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_ctrs(input string tag, input int lk, input int up, input int mp,
                            input int tr);
    dbg_sel = 2'd0; #1; check({tag, " lookup_count"}, int'(dbg_data), lk);
    dbg_sel = 2'd1; #1; check({tag, " update_count"}, int'(dbg_data), up);
    dbg_sel = 2'd2; #1; check({tag, " mispred_count"}, int'(dbg_data), mp);
    dbg_sel = 2'd3; #1; check({tag, " train_count"}, int'(dbg_data), tr);
  endtask

  task automatic check_pred(input string tag, input int sum_nb, input int bias,
                            input logic taken, input logic [11:0] ghr);
    check({tag, " pred_valid"}, int'(pred_valid), 1);
    check({tag, " pred_sum"}, int'($signed(pred_sum)), sum_nb + (BiasOn ? bias : 0));
    check({tag, " pred_taken"}, int'(pred_taken), int'(taken));
    check({tag, " pred_ghr"}, int'(pred_ghr), int'(ghr));
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_pc    = pc;
    lookup_valid = 1'b1;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic taken, input int sum,
                            input logic [11:0] ghr, input logic mp);
    update_pc      = pc;
    update_taken   = taken;
    update_sum     = sum[SW-1:0];
    update_ghr     = ghr;
    update_mispred = mp;
    update_valid   = 1'b1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input int sum,
                           input logic [11:0] ghr, input logic mp);
    set_update(pc, taken, sum, ghr, mp);
    tick();
    update_valid = 1'b0;
  endtask

  // Bounded wait for lookup_ready; reports the number of cycles it took.
  task automatic wait_ready(input string name, input int exp_cycles);
    int cnt = 0;
    while (!lookup_ready && cnt < 200) begin
      tick();
      cnt++;
    end
    check(name, cnt, exp_cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Threshold / training vectors. Rows: 0x44->17, 0x48->18, 0x4C->19, 0x54->21.
    uv[0] = '{32'h44, 1'b1, 1'b0,  38, 12'hFFF, 1, 0, 0};  // |sum| 38: no train
    uv[1] = '{32'h44, 1'b1, 1'b0, -38, 12'hFFF, 2, 0, 0};
    uv[2] = '{32'h44, 1'b1, 1'b0,  37, 12'hFFF, 3, 0, 1};  // boundary: train
    uv[3] = '{32'h44, 1'b1, 1'b0, -37, 12'hFFF, 4, 0, 2};  // row17 w=+2, bias=+2
    uv[4] = '{32'h48, 1'b0, 1'b1, 500, 12'h0F0, 5, 1, 3};  // mispred: w[4..7]=-1 else +1
    uv[5] = '{32'h4C, 1'b0, 1'b0,   0, 12'h000, 6, 1, 4};  // row19 w=+1, bias=-1
    uv[6] = '{32'h54, 1'b0, 1'b0,   0, 12'hFFF, 7, 1, 5};  // row21 w=-1, bias=-1

    // History after uv[4] repair is 0x1E0; each lookup then shifts in its outcome.
    lv[0] = '{32'h44, -8,  2, 1'b0, 12'h1E0};
    lv[1] = '{32'h48, -4, -1, 1'b0, 12'h3C0};
    lv[2] = '{32'h4C, -4, -1, 1'b0, 12'h780};
    lv[3] = '{32'h40,  0,  0, 1'b1, 12'hF00};

    reset = 1'b1;
    lookup_valid = 1'b0;  lookup_pc = '0;
    update_valid = 1'b0;  update_pc = '0;  update_taken = 1'b0;
    update_sum = '0;      update_ghr = '0; update_mispred = 1'b0;
    dbg_sel = 2'd0;

    // Reset state and init length
    tick();
    tick();
    check("reset lookup_ready", int'(lookup_ready), 0);
    check("reset pred_valid", int'(pred_valid), 0);
    check("reset pred_sum", int'(pred_sum), 0);
    check("reset pred_ghr", int'(pred_ghr), 0);
    check_ctrs("reset", 0, 0, 0, 0);
    reset = 1'b0;
    wait_ready("init cycles", 64);

    // First lookup on a cleared table
    do_lookup(32'h40);
    check_pred("first", 0, 0, 1'b1, 12'h000);
    tick();
    check("pred one cycle", int'(pred_valid), 0);

    // Training threshold table
    for (int k = 0; k < 7; k++) begin
      do_update(uv[k].pc, uv[k].taken, uv[k].sum, uv[k].ghr, uv[k].mispred);
      check_ctrs($sformatf("upd%0d", k), 1, uv[k].exp_upd, uv[k].exp_mp, uv[k].exp_tr);
    end

    // Lookups reading the trained rows, history advancing speculatively
    for (int k = 0; k < 4; k++) begin
      do_lookup(lv[k].pc);
      check_pred($sformatf("lk%0d", k), lv[k].sum_nb, lv[k].bias, lv[k].taken, lv[k].ghr);
      tick();
    end

    // Saturation: 140 consecutive trainings of row 0 toward +127
    set_update(32'h100, 1'b1, 0, 12'hFFF, 1'b0);
    repeat (140) tick();
    update_valid = 1'b0;
    check_ctrs("sat", 5, 147, 1, 145);
    do_update(32'h50, 1'b1, 0, 12'hFFF, 1'b1);   // repair history to all ones
    check_ctrs("repair", 5, 148, 2, 146);
    do_lookup(32'h100);
    check_pred("saturated", 127 * 12, 127, 1'b1, 12'hFFF);
    tick();

    // Same-row lookup and training in one cycle: old weights seen first
    lookup_pc = 32'h4C;
    lookup_valid = 1'b1;
    set_update(32'h4C, 1'b1, 0, 12'hFFF, 1'b0);
    tick();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    check_pred("same-cycle old", 12, -1, 1'b1, 12'hFFF);
    tick();
    do_lookup(32'h4C);
    check_pred("after train", 24, 0, 1'b1, 12'hFFF);
    tick();
    check_ctrs("same-row", 8, 149, 2, 147);

    // Back-to-back T,N,T with a repair landing on the third prediction
    lookup_pc = 32'h100;
    lookup_valid = 1'b1;
    tick();
    check_pred("b2b A", 127 * 12, 127, 1'b1, 12'hFFF);
    lookup_pc = 32'h54;
    tick();
    check_pred("b2b B", -12, -1, 1'b0, 12'hFFF);
    lookup_pc = 32'h40;
    tick();
    check_pred("b2b C", 0, 0, 1'b1, 12'hFFE);
    lookup_valid = 1'b0;
    do_update(32'h58, 1'b0, 0, 12'h0AA, 1'b1);
    check("b2b end pred_valid", int'(pred_valid), 0);
    do_lookup(32'h40);
    check_pred("recovered", 0, 0, 1'b1, 12'h154);
    tick();
    check_ctrs("b2b", 12, 150, 3, 148);

    // Reset in RUN with a lookup pending, then a reset pulse mid-INIT
    lookup_pc = 32'h40;
    lookup_valid = 1'b1;
    reset = 1'b1;
    tick();
    lookup_valid = 1'b0;
    check("reset drops pred", int'(pred_valid), 0);
    check("reset ready low", int'(lookup_ready), 0);
    reset = 1'b0;
    repeat (30) tick();
    check("init row30 ready", int'(lookup_ready), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("restart cycles", 64);
    check_ctrs("restart", 0, 0, 0, 0);
    do_lookup(32'h100);
    check_pred("cleared", 0, 0, 1'b1, 12'h000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
